l1_trigger_mc: RTL and testbench

//  Multi-channel, parametrised successor of the nano L1 trigger. Each event is CH
//  (energy, isol) signed pairs. Channels are scored one per cycle by a single

---
 rtl/l1t_pkg.sv | 30 +++
 rtl/l1t_channel_mac.sv | 35 +++
 rtl/l1_trigger_mc.sv | 136 +++++++++++++
 tb/tb_l1_trigger_mc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l1t_pkg.sv
// Shared definitions for the l1_trigger_mc block: FSM state encodings and width helpers.
package l1t_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (clog2(n) > 0) ? clog2(n) : 1;
    endfunction

    // Wide enough that the sum of CH ReLU terms can never overflow.
    function automatic int acc_width(input int w, input int ch);
        return 2 * w + 2 + clog2(ch);
    endfunction

endpackage

// File: rtl/l1t_channel_mac.sv
// Combinational per-channel score: max(0, WE*energy + WI*isol + BIAS), all signed,
// returned as an unsigned ACC_W-bit term.
module l1t_channel_mac
    import l1t_pkg::*;
#(
    parameter int W     = 8,
    parameter int WE    = 2,
    parameter int WI    = 1,
    parameter int BIAS  = -64,
    parameter int ACC_W = acc_width(W, 1)
) (
    input  logic [W-1:0]     energy,
    input  logic [W-1:0]     isol,
    output logic [ACC_W-1:0] s
);

    function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] v);
        return {{(ACC_W - W){v[W-1]}}, v};
    endfunction

    // Weights are W-bit signed quantities; the bias is sign-extended from its full value.
    localparam logic signed [ACC_W-1:0] WE_X   = sext(W'(WE));
    localparam logic signed [ACC_W-1:0] WI_X   = sext(W'(WI));
    localparam logic signed [ACC_W-1:0] BIAS_X = ACC_W'(BIAS);

    logic signed [ACC_W-1:0] energy_x;
    logic signed [ACC_W-1:0] isol_x;
    logic signed [ACC_W-1:0] term;

    assign energy_x = sext(energy);
    assign isol_x   = sext(isol);
    assign term     = energy_x * WE_X + isol_x * WI_X + BIAS_X;
    assign s        = term[ACC_W-1] ? '0 : term;

endmodule

// File: rtl/l1_trigger_mc.sv
// Multi-channel L1 trigger: one shared MAC scores CH channels serially, sums and thresholds.
// Optional prescaler on non-vetoed passes is compiled in with `define L1T_PRESCALE_EN.
module l1_trigger_mc
    import l1t_pkg::*;
#(
    parameter int W        = 8,
    parameter int CH       = 4,
    parameter int WE       = 2,
    parameter int WI       = 1,
    parameter int BIAS     = -64,
    parameter int THRESH   = 200,
    parameter int HOLDOFF  = 8,
    parameter int PRESCALE = 1,
    localparam int ACC_W   = acc_width(W, CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH*W-1:0]   energy,
    input  logic [CH*W-1:0]   isol,
    output logic              dec_valid,
    output logic              trigger,
    output logic              vetoed,
    output logic [ACC_W-1:0]  score
);

    localparam int IDX_W = cnt_width(CH);
    localparam int HO_W  = cnt_width(HOLDOFF + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CH - 1);
    localparam logic [ACC_W-1:0] THRESH_X  = ACC_W'(THRESH);
    localparam logic [HO_W-1:0]  HOLDOFF_X = HO_W'(HOLDOFF);

    logic [1:0]       state;
    logic [IDX_W-1:0] ch_idx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] s_sel;
    logic [HO_W-1:0]  holdoff_cnt;
    logic [CH*W-1:0]  energy_q;
    logic [CH*W-1:0]  isol_q;
    logic             pass;
    logic             hold_busy;

    l1t_channel_mac #(
        .W     (W),
        .WE    (WE),
        .WI    (WI),
        .BIAS  (BIAS),
        .ACC_W (ACC_W)
    ) u_mac (
        .energy (energy_q[ch_idx*W +: W]),
        .isol   (isol_q[ch_idx*W +: W]),
        .s      (s_sel)
    );

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign dec_valid = (state == ST_DECIDE) && !rst;
    assign pass      = acc >= THRESH_X;
    assign hold_busy = holdoff_cnt != '0;
    assign vetoed    = dec_valid && pass && hold_busy;
    assign score     = dec_valid ? acc : '0;

`ifdef L1T_PRESCALE_EN
    localparam int PS_W = cnt_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] presc_cnt;
    logic            eligible;

    assign eligible = dec_valid && pass && !hold_busy;
    assign trigger  = eligible && (presc_cnt == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (eligible) begin
            presc_cnt <= (presc_cnt == PS_LAST) ? '0 : presc_cnt + 1'b1;
        end
    end
`else
    // Keeps PRESCALE referenced when prescaling is compiled out.
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign trigger         = dec_valid && pass && !hold_busy;
`endif

    // Holdoff runs independently of the FSM; a veto does not reload it.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdoff_cnt <= '0;
        end else if (trigger) begin
            holdoff_cnt <= HOLDOFF_X;
        end else if (hold_busy) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ch_idx <= '0;
            acc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state  <= ST_ACCUM;
                        ch_idx <= '0;
                        acc    <= '0;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + s_sel;
                    if (ch_idx == LAST_IDX) begin
                        ch_idx <= '0;
                        state  <= ST_DECIDE;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                ST_DECIDE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: sample registers carry no reset; they are always loaded before the FSM reads them.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            energy_q <= energy;
            isol_q   <= isol;
        end
    end

endmodule

// File: tb/tb_l1_trigger_mc.sv
// Scoreboard bench for l1_trigger_mc: directed cases plus randomized events against a
// behavioural model of score, holdoff window and prescale (honours L1T_PRESCALE_EN).
module tb_l1_trigger_mc;

    localparam int W        = 8;
    localparam int CH       = 4;
    localparam int WE       = 2;
    localparam int WI       = 1;
    localparam int BIAS     = -64;
    localparam int THRESH   = 200;
    localparam int HOLDOFF  = 8;
    localparam int PRESCALE = 3;
    localparam int ACC_W    = 2 * W + 2 + 2;
`ifdef L1T_PRESCALE_EN
    localparam int EFF_PS = PRESCALE;
`else
    localparam int EFF_PS = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CH*W-1:0]   energy;
    logic [CH*W-1:0]   isol;
    logic              dec_valid;
    logic              trigger;
    logic              vetoed;
    logic [ACC_W-1:0]  score;

    l1_trigger_mc #(
        .W(W), .CH(CH), .WE(WE), .WI(WI), .BIAS(BIAS),
        .THRESH(THRESH), .HOLDOFF(HOLDOFF), .PRESCALE(PRESCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .energy    (energy),
        .isol      (isol),
        .dec_valid (dec_valid),
        .trigger   (trigger),
        .vetoed    (vetoed),
        .score     (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        bit trig;
        bit veto;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   m_have_trig;
    int   m_last_trig;
    int   m_pass_cnt;

    // Count of rising edges so far; stable whenever the bench samples or drives.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int ref_score(input logic [CH*W-1:0] e, input logic [CH*W-1:0] i);
        int sum;
        sum = 0;
        for (int c = 0; c < CH; c++) begin
            int t;
            t = WE * int'($signed(e[c*W +: W])) + WI * int'($signed(i[c*W +: W])) + BIAS;
            if (t > 0) sum += t;
        end
        return sum;
    endfunction

    function automatic logic [CH*W-1:0] fill(input int n, input int v);
        logic [CH*W-1:0] r;
        r = '0;
        for (int c = 0; c < n; c++) r[c*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [CH*W-1:0] rand_vec();
        logic [CH*W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        m_have_trig = 1'b0;
        m_last_trig = 0;
        m_pass_cnt  = 0;
    endtask

    // A trigger decided at cycle D vetoes any pass decided at D+1 .. D+HOLDOFF.
    task automatic predict(input logic [CH*W-1:0] e, input logic [CH*W-1:0] i, input int dcyc);
        exp_t x;
        bit   pass;
        bit   busy;
        x.score = ref_score(e, i);
        pass    = x.score >= THRESH;
        busy    = m_have_trig && ((dcyc - m_last_trig) <= HOLDOFF);
        x.veto  = pass && busy;
        x.trig  = 1'b0;
        if (pass && !busy) begin
            m_pass_cnt++;
            x.trig = (m_pass_cnt % EFF_PS) == 0;
        end
        if (x.trig) begin
            m_have_trig = 1'b1;
            m_last_trig = dcyc;
        end
        x.cyc = dcyc;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [CH*W-1:0] e, input logic [CH*W-1:0] i, input bit expect_dec);
        int waited;
        waited   = 0;
        energy   = e;
        isol     = i;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 4 * CH + 8) begin
                check("in_ready_wait", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (expect_dec) predict(e, i, cyc + 1 + CH);
        @(negedge clk);
        in_valid = 1'b0;
        energy   = rand_vec();
        isol     = rand_vec();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a decision.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (dec_valid) begin
                check("dec_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    check("score", score, x.score);
                    check("trigger", trigger, x.trig);
                    check("vetoed", vetoed, x.veto);
                    check("latency", cyc, x.cyc);
                end
            end else if (trigger || vetoed) begin
                check("pulse_without_dec", {trigger, vetoed}, 0);
            end
            if (trigger && vetoed) check("trigger_and_vetoed", 1, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        energy   = '0;
        isol     = '0;
        model_reset();
        idle(3);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_dec_valid", dec_valid, 0);
        check("reset_trigger", trigger, 0);
        check("reset_vetoed", vetoed, 0);
        check("reset_score", score, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready, 1);
        idle(1);

        // All channels below bias: every term clamps to zero.
        send(fill(CH, 15), fill(CH, 10), 1'b1);
        idle(12);

        // Single hot channel triggers; back-to-back pass lands inside holdoff.
        send(fill(1, 110), fill(1, 90), 1'b1);
        send(fill(3, 60), fill(3, 40), 1'b1);
        idle(12);

        // Below threshold, then above threshold once holdoff has expired.
        send(fill(2, 60), fill(2, 40), 1'b1);
        send(fill(3, 60), fill(3, 40), 1'b1);
        idle(12);

        // Most-negative samples: sign handling and ReLU clamp.
        send(fill(CH, -128), fill(CH, -128), 1'b1);
        idle(12);

        // Threshold boundary: 199 fails, 200 passes.
        send(fill(1, 100), fill(1, 63), 1'b1);
        send(fill(1, 100), fill(1, 64), 1'b1);
        idle(12);

        // Reset mid-ACCUM aborts the event.
        send(fill(1, 110), fill(1, 90), 1'b0);
        idle(1);
        rst = 1'b1;
        #1;
        check("abort_in_ready_in_reset", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_in_ready_after", in_ready, 1);
        send(fill(3, 60), fill(3, 40), 1'b1);
        idle(12);

        // Six passing events spaced beyond holdoff: prescaler decides which fire.
        for (int n = 0; n < 6; n++) begin
            send(fill(1, 110), fill(1, 90), 1'b1);
            idle(HOLDOFF + 2);
        end

        // Randomized traffic with random gaps.
        for (int n = 0; n < 40; n++) begin
            idle($urandom_range(0, 10));
            send(rand_vec(), rand_vec(), 1'b1);
        end

        idle(3 * CH + 10);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
